regs_wb_ctrl: RTL and testbench
===============================

# regs_wb_ctrl

Write-back controller for the integer register file. Arbitrates write requests from NR_SRC producers (ALU, load unit, CSR, ...) onto the file's single write port with a round-robin arbiter and a registered output stage. Maintains a per-register pending-write scoreboard so the issue stage can detect RAW/WAW hazards on its two source operands and its destination. Sits between the execute/memory stages and the register file: drives the file's wen/addrw/dinw and post-processes its douta/doutb.

## Interface
- WIDTH, 32: register data width
- NR_REGS, 32: number of architectural registers; register 0 is hard-wired zero
- ADDR_WIDTH, 5: register address width
- NR_SRC, 3: number of write-back requesters, 2..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- src_valid  in  NR_SRC  per-source write request
- src_ready  out  NR_SRC  per-source grant; handshake = valid & ready
- src_addr  in  NR_SRC*ADDR_WIDTH  flat destination addresses, source k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- src_data  in  NR_SRC*WIDTH  flat write data, source k at [k*WIDTH +: WIDTH]
- hold  in  1  freeze arbitration (no grants while high)
- wen / addrw / dinw  out  1 / ADDR_WIDTH / WIDTH  registered write port to the register file
- set_en, set_addr  in  1, ADDR_WIDTH  issue stage marks set_addr pending
- qa_addr, qb_addr, qd_addr  in  ADDR_WIDTH  issue-stage query addresses (src a, src b, dest)
- rf_douta, rf_doutb  in  WIDTH  register file read data for qa_addr/qb_addr
- opa, opb  out  WIDTH  operand data to issue stage
- busy_a, busy_b, busy_d  out  1  pending-write flags for the queries

## Operation
- Arbiter: round-robin over src_valid; a pointer last_grant (reset NR_SRC-1) sets priority to last_grant+1 upward, wrapping. At most one src_ready high per cycle, only when that source is valid and hold=0. last_grant updates only on a handshake.
- Output stage: a handshake in cycle N loads wen=1, addrw=src_addr[k], dinw=src_data[k] for cycle N+1; with no handshake, wen=0 and addrw/dinw hold. A handshake to address 0 is accepted but produces wen=0.
- Scoreboard: NR_REGS-1 bits (reg 0 is never busy). set_en sets bit set_addr at the edge; wen=1 clears bit addrw at the edge. When set and clear hit the same address in one cycle, set wins. set_en with set_addr=0 is ignored. set_en on an already-busy register is illegal; issue must stall on busy_d.
- busy_x = scoreboard[q_addr] (combinational; 0 for address 0). opa/opb = rf_douta/rf_doutb.
- Reset (rst low, asynchronous): wen=0, addrw=0, dinw=0, scoreboard all clear, last_grant=NR_SRC-1; src_ready=0 while in reset. Reset mid-request drops the pending output write.

## Timing
- Grant is combinational in cycle N; register file write takes effect at the end of cycle N+1; the scoreboard bit clears at the same edge, so busy drops in N+2.
- Set-to-busy latency: 1 cycle (busy visible the cycle after set_en).
- Throughput: one write per cycle; sources that are continuously valid receive grants in strict rotation.

## Configuration
- REGS_WB_BYPASS_EN defined: during the cycle wen=1, any query with address equal to addrw (non-zero) gets opa/opb=dinw and busy_a/busy_b=0; busy_d is unaffected. This saves one stall cycle per dependency.
- Undefined: no forwarding; opa/opb are pure pass-through and busy reflects the scoreboard only.

## Structure
- Package regs_ctrl_pkg: default WIDTH/ADDR_WIDTH/NR_REGS/NR_SRC constants and a localparam for the zero-register address.
- Sub-module rr_arbiter (NR parameter): valid vector, hold and advance inputs; one-hot grant output and grant index output; owns the last_grant pointer.
- regs_wb_ctrl instantiates rr_arbiter and owns the output stage, the scoreboard and the bypass muxes.

## Test plan
- Reset: with rst low and all src_valid=1, src_ready=0, wen=0, all busy=0; after release the first grant goes to source 0.
- Rotation: NR_SRC=3, all valid for 6 cycles. Grants are 0,1,2,0,1,2, and wen shows the matching addr/data one cycle later.
- Scoreboard: set_en with set_addr=5 in cycle 0 gives busy_d=1 at qd_addr=5 from cycle 1. Source 1 writes reg 5 with data 0xDEADBEEF in cycle 3, wen in cycle 4, and busy returns to 0 in cycle 5 while rf reads 0xDEADBEEF.
- Zero register: set_addr=0 leaves busy=0. A write to addr 0 is handshaken, wen stays 0, and the next grant rotates normally.
- Set/clear collision: set_en on reg 7 in the same cycle wen=1/addrw=7 leaves busy 7 at 1 afterwards.
- Bypass (macro defined): with wen=1, addrw=3, dinw=0x12345678 and qa_addr=3 in the same cycle, opa=0x12345678 and busy_a=0. With the macro undefined the same stimulus gives opa=rf_douta and busy_a=1.

Source files
------------

// File: rtl/regs_ctrl_pkg.sv
// Shared defaults for the register-file write-back controller.
package regs_ctrl_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_NR_REGS    = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NR_SRC     = 3;

  localparam logic [DEF_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts just above the last winner and wraps.
module rr_arbiter #(
  parameter  int NR = 3,
  localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NR-1:0] valid,
  input  logic          hold,
  input  logic          advance,
  output logic [NR-1:0] grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_grant_r;
  logic [IW:0]   cand_s;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Search NR candidates starting one above last_grant; no grant in reset or on hold.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant_r;
    found_s   = 1'b0;
    cand_s    = '0;
    idx_s     = '0;
    if (rst_n && !hold) begin
      for (int i = 1; i <= NR; i++) begin
        cand_s = {1'b0, last_grant_r} + (IW+1)'(i);
        if (cand_s >= (IW+1)'(NR)) begin
          cand_s = cand_s - (IW+1)'(NR);
        end else begin
          cand_s = cand_s;
        end
        idx_s = cand_s[IW-1:0];
        if (!found_s && valid[idx_s]) begin
          found_s        = 1'b1;
          grant[idx_s]   = 1'b1;
          grant_idx      = idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  // Pointer moves only on an accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= IW'(NR - 1);
    end else if (advance) begin
      last_grant_r <= grant_idx;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Write-back controller: arbitrates producers onto the register-file write port and
// tracks pending writes. Define REGS_WB_BYPASS_EN to forward dinw to the operand reads.
module regs_wb_ctrl
  import regs_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NR_REGS    = DEF_NR_REGS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_SRC     = DEF_NR_SRC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_SRC-1:0]            src_valid,
  output logic [NR_SRC-1:0]            src_ready,
  input  logic [NR_SRC*ADDR_WIDTH-1:0] src_addr,
  input  logic [NR_SRC*WIDTH-1:0]      src_data,
  input  logic                         hold,
  output logic                         wen,
  output logic [ADDR_WIDTH-1:0]        addrw,
  output logic [WIDTH-1:0]             dinw,
  input  logic                         set_en,
  input  logic [ADDR_WIDTH-1:0]        set_addr,
  input  logic [ADDR_WIDTH-1:0]        qa_addr,
  input  logic [ADDR_WIDTH-1:0]        qb_addr,
  input  logic [ADDR_WIDTH-1:0]        qd_addr,
  input  logic [WIDTH-1:0]             rf_douta,
  input  logic [WIDTH-1:0]             rf_doutb,
  output logic [WIDTH-1:0]             opa,
  output logic [WIDTH-1:0]             opb,
  output logic                         busy_a,
  output logic                         busy_b,
  output logic                         busy_d
);

  localparam int IW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [IW-1:0]         grant_idx_s;
  logic                  handshake_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WIDTH-1:0]      sel_data_s;
  logic [NR_REGS-1:1]    sb_r;
  logic [NR_REGS-1:1]    sb_nxt_s;
  logic                  hit_a_s;
  logic                  hit_b_s;

  function automatic logic sb_lookup(input logic [NR_REGS-1:1] sb,
                                     input logic [ADDR_WIDTH-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 1; i < NR_REGS; i++) begin
      if (a == ADDR_WIDTH'(i)) r = sb[i];
      else r = r;
    end
    return r;
  endfunction

  rr_arbiter #(.NR(NR_SRC)) u_arb (
    .clk       (clk),
    .rst_n     (rst),
    .valid     (src_valid),
    .hold      (hold),
    .advance   (handshake_s),
    .grant     (src_ready),
    .grant_idx (grant_idx_s)
  );

  assign handshake_s = |src_ready;
  assign sel_addr_s  = src_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data_s  = src_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  // Registered write port; an accepted write to the zero register never asserts wen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen   <= 1'b0;
      addrw <= '0;
      dinw  <= '0;
    end else if (handshake_s) begin
      wen   <= (sel_addr_s != ZERO_ADDR);
      addrw <= sel_addr_s;
      dinw  <= sel_data_s;
    end else begin
      wen   <= 1'b0;
    end
  end

  // Next scoreboard: a set beats a same-cycle clear so the new producer stays tracked.
  always_comb begin
    sb_nxt_s = sb_r;
    for (int i = 1; i < NR_REGS; i++) begin
      if (set_en && set_addr == ADDR_WIDTH'(i)) begin
        sb_nxt_s[i] = 1'b1;
      end else if (wen && addrw == ADDR_WIDTH'(i)) begin
        sb_nxt_s[i] = 1'b0;
      end else begin
        sb_nxt_s[i] = sb_r[i];
      end
    end
  end

  // Pending-write scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_r <= '0;
    end else begin
      sb_r <= sb_nxt_s;
    end
  end

`ifdef REGS_WB_BYPASS_EN
  assign hit_a_s = wen && (qa_addr == addrw) && (qa_addr != ZERO_ADDR);
  assign hit_b_s = wen && (qb_addr == addrw) && (qb_addr != ZERO_ADDR);
`else
  assign hit_a_s = 1'b0;
  assign hit_b_s = 1'b0;
`endif

  // Operand muxes and hazard flags toward the issue stage.
  always_comb begin
    opa    = rf_douta;
    opb    = rf_doutb;
    busy_a = 1'b0;
    busy_b = 1'b0;
    busy_d = sb_lookup(sb_r, qd_addr);
    if (hit_a_s) begin
      opa    = dinw;
      busy_a = 1'b0;
    end else begin
      busy_a = sb_lookup(sb_r, qa_addr);
    end
    if (hit_b_s) begin
      opb    = dinw;
      busy_b = 1'b0;
    end else begin
      busy_b = sb_lookup(sb_r, qb_addr);
    end
  end

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Scoreboard bench for regs_wb_ctrl: models arbitration, write port, pending bits and the register file.
module tb_regs_wb_ctrl;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int NREGS = 32;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         src_valid;
  logic [NR-1:0]         src_ready;
  logic [NR-1:0][AW-1:0] s_addr;
  logic [NR-1:0][W-1:0]  s_data;
  logic                  hold;
  logic                  wen;
  logic [AW-1:0]         addrw;
  logic [W-1:0]          dinw;
  logic                  set_en;
  logic [AW-1:0]         set_addr, qa_addr, qb_addr, qd_addr;
  logic [W-1:0]          rf_douta, rf_doutb, opa, opb;
  logic                  busy_a, busy_b, busy_d;

  logic [W-1:0]          rf_mem [NREGS];
  logic [NREGS-1:0]      mbusy;
  int                    mptr;
  wr_t                   exp_q[$];
  int                    n_chk = 0;
  int                    n_err = 0;

  assign rf_douta = rf_mem[qa_addr];
  assign rf_doutb = rf_mem[qb_addr];

  always #5 clk = ~clk;

  regs_wb_ctrl #(.WIDTH(W), .NR_REGS(NREGS), .ADDR_WIDTH(AW), .NR_SRC(NR)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(s_addr), .src_data(s_data), .hold(hold),
    .wen(wen), .addrw(addrw), .dinw(dinw),
    .set_en(set_en), .set_addr(set_addr),
    .qa_addr(qa_addr), .qb_addr(qb_addr), .qd_addr(qd_addr),
    .rf_douta(rf_douta), .rf_doutb(rf_doutb), .opa(opa), .opb(opb),
    .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, push the next expected write, advance the model.
  task automatic cycle();
    wr_t           e;
    wr_t           nx;
    logic [NR-1:0] er;
    int            gi;
    int            idx;
    logic          eba, ebb, ebd;
    logic [W-1:0]  eoa, eob;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    chk("wen", wen, e.wen);
    if (e.wen) begin
      chk("addrw", addrw, e.addr);
      chk("dinw", dinw, e.data);
    end
    er = '0;
    gi = -1;
    if (!hold) begin
      for (int i = 1; i <= NR; i++) begin
        idx = (mptr + i) % NR;
        if (gi < 0 && src_valid[idx]) begin
          gi = idx;
          er[idx] = 1'b1;
        end
      end
    end
    chk("src_ready", src_ready, er);
    eba = (qa_addr != 0) && mbusy[qa_addr];
    ebb = (qb_addr != 0) && mbusy[qb_addr];
    ebd = (qd_addr != 0) && mbusy[qd_addr];
    eoa = rf_mem[qa_addr];
    eob = rf_mem[qb_addr];
`ifdef REGS_WB_BYPASS_EN
    if (e.wen && qa_addr == e.addr && qa_addr != 0) begin eoa = e.data; eba = 1'b0; end
    if (e.wen && qb_addr == e.addr && qb_addr != 0) begin eob = e.data; ebb = 1'b0; end
`endif
    chk("busy_a", busy_a, eba);
    chk("busy_b", busy_b, ebb);
    chk("busy_d", busy_d, ebd);
    chk("opa", opa, eoa);
    chk("opb", opb, eob);
    nx = '0;
    if (gi >= 0) begin
      nx.wen  = (s_addr[gi] != 0);
      nx.addr = s_addr[gi];
      nx.data = s_data[gi];
      mptr    = gi;
    end
    exp_q.push_back(nx);
    if (e.wen) begin
      mbusy[e.addr]  = 1'b0;
      rf_mem[e.addr] = e.data;
    end
    if (set_en && set_addr != 0) mbusy[set_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    src_valid = '1;
    hold = 1'b0;
    set_en = 1'b0;
    set_addr = '0;
    qa_addr = 5'd1;
    qb_addr = 5'd2;
    qd_addr = 5'd3;
    for (int k = 0; k < NR; k++) begin
      s_addr[k] = AW'(10 + k);
      s_data[k] = W'(k + 1);
    end
    for (int r = 0; r < NREGS; r++) rf_mem[r] = W'(32'hA000_0000 + r);
    mbusy = '0;
    mptr = NR - 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", src_ready, 3'b000);
    chk("rst_wen", wen, 1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_busy_d", busy_d, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back(wr_t'(0));

    // rotation with all sources valid
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < NR; k++) s_data[k] = $urandom;
      cycle();
    end
    src_valid = '0;
    cycle();

    // hold blocks grants
    src_valid = '1;
    hold = 1'b1;
    cycle();
    cycle();
    hold = 1'b0;
    src_valid = '0;
    cycle();

    // scoreboard set, write-back and clear
    qd_addr = 5'd5;
    qa_addr = 5'd5;
    set_en = 1'b1;
    set_addr = 5'd5;
    cycle();
    set_en = 1'b0;
    cycle();
    cycle();
    src_valid = 3'b010;
    s_addr[1] = 5'd5;
    s_data[1] = 32'hDEAD_BEEF;
    cycle();
    src_valid = '0;
    cycle();
    cycle();
    chk("opa_written", opa, 32'hDEAD_BEEF);
    chk("busy_d_cleared", busy_d, 1'b0);

    // zero register
    set_en = 1'b1;
    set_addr = 5'd0;
    qd_addr = 5'd0;
    cycle();
    set_en = 1'b0;
    src_valid = 3'b100;
    s_addr[2] = 5'd0;
    s_data[2] = 32'h0000_AAAA;
    cycle();
    src_valid = '1;
    s_addr[0] = 5'd20;
    s_addr[1] = 5'd21;
    s_addr[2] = 5'd22;
    cycle();
    cycle();
    src_valid = '0;
    cycle();

    // set and clear on the same register in one cycle
    src_valid = 3'b001;
    s_addr[0] = 5'd7;
    s_data[0] = 32'h0000_0777;
    qd_addr = 5'd7;
    cycle();
    src_valid = '0;
    set_en = 1'b1;
    set_addr = 5'd7;
    cycle();
    set_en = 1'b0;
    cycle();
    chk("collision_busy", busy_d, 1'b1);

    // forwarding window on a pending register
    set_en = 1'b1;
    set_addr = 5'd3;
    cycle();
    set_en = 1'b0;
    src_valid = 3'b001;
    s_addr[0] = 5'd3;
    s_data[0] = 32'h1234_5678;
    qa_addr = 5'd3;
    qb_addr = 5'd3;
    cycle();
    src_valid = '0;
    cycle();
    cycle();

    // reset in the middle of a request drops the pending write
    src_valid = 3'b001;
    s_addr[0] = 5'd9;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", src_ready, 3'b000);
    @(posedge clk);
    #1;
    chk("midrst_wen", wen, 1'b0);
    chk("midrst_busy_d", busy_d, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
